apu_mixer_sd: RTL

APU_MIXER_SD -- requirements
Module: apu_mixer_sd

---
 rtl/apu_pkg.sv | 14 +
 rtl/apu_mixer_sd_if.sv | 8 +
 rtl/apu_pwm_dsm.sv | 42 ++++
 rtl/apu_mixer_sd.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared definitions for the APU mixer: FSM encoding, modulator selectors and
// control-field widths.
package apu_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2
  } apu_state_e;

  localparam int MODE_PWM = 0;
  localparam int MODE_DSM = 1;
  localparam int GAIN_W   = 4;
  localparam int VOL_W    = 4;
endpackage

// File: rtl/apu_mixer_sd_if.sv
// Link between the mixer core and its 1-bit output modulator.
interface apu_mixer_sd_if #(parameter int OUT_W = 8) ();
  logic [OUT_W-1:0] pcm;
  logic             audio;

  modport master (output pcm, input audio);
  modport slave  (input pcm, output audio);
endinterface

// File: rtl/apu_pwm_dsm.sv
// 1-bit audio modulator: free-running PWM compare or first-order delta-sigma.
module apu_pwm_dsm
  import apu_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int MODE  = MODE_PWM
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  apu_mixer_sd_if.slave  mod
);

  generate
    if (MODE == MODE_DSM) begin : g_dsm
      logic [OUT_W:0] r_acc;

      // Carry out of the low OUT_W bits is the 1-bit density stream.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_acc <= '0;
        else           r_acc <= {1'b0, r_acc[OUT_W-1:0]} + {1'b0, mod.pcm};
      end

      assign mod.audio = r_acc[OUT_W];
    end else begin : g_pwm
      logic [OUT_W-1:0] r_cnt;
      logic             r_audio;

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          r_cnt   <= '0;
          r_audio <= 1'b0;
        end else begin
          r_cnt   <= r_cnt + OUT_W'(1);
          r_audio <= (mod.pcm > r_cnt);
        end
      end

      assign mod.audio = r_audio;
    end
  endgenerate

endmodule

// File: rtl/apu_mixer_sd.sv
// Sequential multi-channel audio mixer: one MAC per cycle, saturate, master
// volume, then a 1-bit modulator on the held PCM value.
module apu_mixer_sd
  import apu_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 4,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 2,
  parameter int MODE   = MODE_PWM
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     sample_in,
  input  logic [NUM_CH-1:0]        mute_in,
  input  logic [NUM_CH*CH_W-1:0]   ch_in,
  input  logic [NUM_CH*GAIN_W-1:0] gain_in,
  input  logic [VOL_W-1:0]         master_vol_in,
  output logic                     busy_out,
  output logic [OUT_W-1:0]         pcm_out,
  output logic                     pcm_valid_out,
  output logic                     overrun_out,
  output logic                     audio_out
);

  localparam int TW    = CH_W + GAIN_W;
  localparam int ACC_W = TW + $clog2(NUM_CH);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int WIDE  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam int PW    = OUT_W + VOL_W;
  localparam logic [WIDE-1:0] PCM_MAX = WIDE'({OUT_W{1'b1}});

  apu_state_e r_state, w_state_nxt;

  logic [NUM_CH-1:0][CH_W-1:0]   r_ch;
  logic [NUM_CH-1:0][GAIN_W-1:0] r_gain;
  logic [NUM_CH-1:0]             r_mute;
  logic [VOL_W-1:0]              r_vol;
  logic [ACC_W-1:0]              r_acc;
  logic [IDX_W-1:0]              r_idx;
  logic                          r_ph;
  logic [OUT_W-1:0]              r_sat, r_pcm;
  logic                          r_valid, r_overrun;

  logic w_accept, w_add, w_sat_ld, w_pcm_ld, w_overrun;
  logic [TW-1:0]    w_term;
  logic [WIDE-1:0]  w_shift;
  logic [OUT_W-1:0] w_sat;
  logic [VOL_W:0]   w_vol_p1;
  logic [PW-1:0]    w_prod;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // SCALE spends two cycles: saturate first, then apply master volume.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_add       = 1'b0;
    w_sat_ld    = 1'b0;
    w_pcm_ld    = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sample_in) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        w_add     = 1'b1;
        w_overrun = sample_in;
        if (r_idx == IDX_W'(NUM_CH - 1)) w_state_nxt = ST_SCALE;
      end
      ST_SCALE: begin
        w_overrun = sample_in;
        if (!r_ph) w_sat_ld = 1'b1;
        else begin
          w_pcm_ld    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_term   = r_mute[r_idx] ? '0 : TW'(r_ch[r_idx]) * TW'(r_gain[r_idx]);
  assign w_shift  = WIDE'(r_acc >> SHIFT);
  assign w_sat    = (w_shift > PCM_MAX) ? {OUT_W{1'b1}} : w_shift[OUT_W-1:0];
  assign w_vol_p1 = {1'b0, r_vol} + (VOL_W+1)'(1);
  assign w_prod   = PW'(r_sat) * PW'(w_vol_p1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ch      <= '0;
      r_gain    <= '0;
      r_mute    <= '0;
      r_vol     <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_ph      <= 1'b0;
      r_sat     <= '0;
      r_pcm     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= w_pcm_ld;
      r_overrun <= w_overrun;
      if (w_accept) begin
        r_ch   <= ch_in;
        r_gain <= gain_in;
        r_mute <= mute_in;
        r_vol  <= master_vol_in;
        r_acc  <= '0;
        r_idx  <= '0;
        r_ph   <= 1'b0;
      end
      if (w_add) begin
        r_acc <= r_acc + ACC_W'(w_term);
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_sat_ld) begin
        r_sat <= w_sat;
        r_ph  <= 1'b1;
      end
      if (w_pcm_ld) begin
        r_pcm <= w_prod[PW-1:VOL_W];
        r_ph  <= 1'b0;
      end
    end
  end

  assign busy_out      = (r_state != ST_IDLE);
  assign pcm_out       = r_pcm;
  assign pcm_valid_out = r_valid;
  assign overrun_out   = r_overrun;

  apu_mixer_sd_if #(.OUT_W(OUT_W)) u_mod_if ();

  assign u_mod_if.pcm = r_pcm;
  assign audio_out    = u_mod_if.audio;

  apu_pwm_dsm #(.OUT_W(OUT_W), .MODE(MODE)) u_mod (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .mod      (u_mod_if.slave)
  );

endmodule
